// File: rtl/rx_fifo.sv
// ---------------------------------------------------------------------------
// rx_fifo
//
// Receive-side byte FIFO between a serial receive unit and the CPU. A small
// capture FSM takes one byte per assertion of the receive unit's rx_rs level.
// It acknowledges each byte with a one-cycle rx_over_read pulse. Accepted
// bytes are queued in a DEPTH-entry circular buffer that the CPU drains with
// rd. A byte that cannot be stored is dropped and the sticky overrun flag is
// raised.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous, active-high reset
//   rx_data      received byte, valid while rx_rs = 1
//   rx_rs        receive unit byte-available level
//   rx_over_read one-cycle registered acknowledge back to the receive unit
//   rd           CPU pop strobe, one pop per high cycle
//   dout         head entry, show-ahead (valid while empty = 0)
//   empty        count == 0
//   full         count == DEPTH
//   count        number of stored bytes, 0..DEPTH
//   overrun      sticky: a byte was dropped
//   clr_ovr      CPU clear of overrun
// ---------------------------------------------------------------------------
module rx_fifo #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    rx_data,
    input  logic          rx_rs,
    output logic          rx_over_read,
    input  logic          rd,
    output logic [7:0]    dout,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   count,
    output logic          overrun,
    input  logic          clr_ovr
);

    localparam int            DATA_W  = 8;
    localparam logic [AW:0]   DEPTH_C = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACK      = 2'd1,
        WAIT_CLR = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;

    logic [DATA_W-1:0]   mem [DEPTH];
    logic [AW-1:0]       wptr;
    logic [AW-1:0]       rptr;
    logic [AW:0]         cnt;
    logic                ovr;
    logic                ack_q;

    logic                push_req;
    logic                push_ok;
    logic                drop;
    logic                pop;

    // A byte is taken only on the IDLE cycle in which rx_rs is seen high. In
    // ACK and WAIT_CLR the level is ignored, so one rx_rs assertion yields
    // one capture.
    assign push_req = (state == IDLE) && rx_rs;
    assign pop      = rd && (cnt != '0);
    // When full, a same-cycle pop frees the slot that the push fills.
    assign push_ok  = push_req && ((cnt != DEPTH_C) || rd);
    assign drop     = push_req && !push_ok;

    // Capture FSM: next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (rx_rs) state_nxt = ACK;
            ACK:      state_nxt = WAIT_CLR;
            WAIT_CLR: if (!rx_rs) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Capture FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Storage, pointers, occupancy and status flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wptr  <= '0;
            rptr  <= '0;
            cnt   <= '0;
            ovr   <= 1'b0;
            ack_q <= 1'b0;
        end else begin
            if (push_ok) begin
                mem[wptr] <= rx_data;
                wptr      <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
            // A new drop wins over a coincident clear.
            if (drop) begin
                ovr <= 1'b1;
            end else if (clr_ovr) begin
                ovr <= 1'b0;
            end
            // Acknowledge every captured byte, stored or dropped; this is
            // high exactly while the FSM sits in ACK.
            ack_q <= push_req;
        end
    end

    assign dout         = mem[rptr];
    assign empty        = (cnt == '0);
    assign full         = (cnt == DEPTH_C);
    assign count        = cnt;
    assign overrun      = ovr;
    assign rx_over_read = ack_q;

endmodule

// File: tb/tb_rx_fifo.sv
module tb_rx_fifo;

    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    rx_data;
    logic          rx_rs;
    logic          rx_over_read;
    logic          rd;
    logic [7:0]    dout;
    logic          empty;
    logic          full;
    logic [AW:0]   count;
    logic          overrun;
    logic          clr_ovr;

    rx_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_data      (rx_data),
        .rx_rs        (rx_rs),
        .rx_over_read (rx_over_read),
        .rd           (rd),
        .dout         (dout),
        .empty        (empty),
        .full         (full),
        .count        (count),
        .overrun      (overrun),
        .clr_ovr      (clr_ovr)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          acks     = 0;

    // Reference model: expected FIFO contents, capture state, overrun flag
    logic [7:0]  sb [$];
    int          mst;      // 0 = IDLE, 1 = ACK, 2 = WAIT_CLR
    logic        ovr_m;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at posedge+1; forces reset asynchronously and checks it before any edge.
    task automatic do_reset();
        rst = 1'b1;
        #2;
        check("rst_count",   count,        0);
        check("rst_empty",   empty,        1);
        check("rst_full",    full,         0);
        check("rst_overrun", overrun,      0);
        check("rst_ack",     rx_over_read, 0);
        check("rst_dout",    dout,         8'h00);
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        mst   = 0;
        ovr_m = 1'b0;
    endtask

    // One clock cycle: drive inputs, advance the model, compare after the edge.
    task automatic step(input logic rs, input logic [7:0] d, input logic r, input logic c);
        logic       push_req;
        logic       push_ok;
        logic       pop;
        logic [7:0] hd;
        int         sz;
        rx_rs   = rs;
        rx_data = d;
        rd      = r;
        clr_ovr = c;
        sz       = sb.size();
        push_req = (mst == 0) && rs;
        pop      = r && (sz != 0);
        push_ok  = push_req && ((sz < DEPTH) || r);
        if (pop) begin
            hd = sb.pop_front();
            check("pop_data", dout, hd);
        end
        if (push_ok) sb.push_back(d);
        if (push_req && !push_ok) ovr_m = 1'b1;
        else if (c) ovr_m = 1'b0;
        case (mst)
            0: if (rs) mst = 1;
            1: mst = 2;
            default: if (!rs) mst = 0;
        endcase
        @(posedge clk); #1;
        check("count",   count,        sb.size());
        check("empty",   empty,        sb.size() == 0);
        check("full",    full,         sb.size() == DEPTH);
        check("overrun", overrun,      ovr_m);
        check("ack",     rx_over_read, push_req);
        if (sb.size() > 0) check("head", dout, sb[0]);
        if (rx_over_read) acks++;
    endtask

    // One full handshake: byte offered for one cycle, then rx_rs low for two.
    task automatic send_byte(input logic [7:0] b, input logic r);
        step(1'b1, b, r, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    initial begin
        int a0;
        rst = 1'b0; rx_data = '0; rx_rs = 1'b0; rd = 1'b0; clr_ovr = 1'b0;
        mst = 0; ovr_m = 1'b0;
        @(posedge clk); #1;
        do_reset();

        // Single byte: visible one clock after rx_rs rises, one acknowledge
        step(1'b1, 8'h55, 1'b0, 1'b0);
        check("t1_count", count, 1);
        check("t1_dout",  dout,  8'h55);
        check("t1_empty", empty, 0);
        check("t1_ack",   rx_over_read, 1);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        check("t1_ack_gone", rx_over_read, 0);
        step(1'b0, 8'h00, 1'b0, 1'b0);

        // Fill to full, then overflow by one
        do_reset();
        for (int i = 1; i <= 8; i++) send_byte(8'(i), 1'b0);
        check("t2_full",  full,  1);
        check("t2_count", count, 8);
        a0 = acks;
        send_byte(8'h09, 1'b0);
        check("t2_ovr",   overrun, 1);
        check("t2_dout",  dout,    8'h01);
        check("t2_acks",  acks - a0, 1);

        // Push into a full FIFO together with a pop
        send_byte(8'h0A, 1'b1);
        check("t3_count", count,   8);
        check("t3_ovr",   overrun, 1);
        check("t3_dout",  dout,    8'h02);
        for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        check("t3_empty", empty, 1);

        // Interleaved pushes and pops wrap both pointers
        do_reset();
        for (int i = 0; i < 12; i++) send_byte(8'h20 + 8'(i), i > 0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check("t4_count", count, 0);
        check("t4_empty", empty, 1);

        // rx_rs held high for 20 cycles: one push, one acknowledge
        a0 = acks;
        for (int i = 0; i < 20; i++) step(1'b1, 8'hA5, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        check("t5_acks",  acks - a0, 1);
        check("t5_count", count, 1);
        check("t5_dout",  dout, 8'hA5);

        // rd on empty is ignored; clear coinciding with a drop keeps overrun
        do_reset();
        step(1'b0, 8'h00, 1'b1, 1'b0);
        check("t6_count", count, 0);
        for (int i = 0; i < 8; i++) send_byte(8'h40 + 8'(i), 1'b0);
        step(1'b1, 8'h77, 1'b0, 1'b1);
        check("t6_ovr_set", overrun, 1);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        check("t6_ovr_clr", overrun, 0);

        // Reset in the middle of a handshake; held rx_rs is a new byte after
        do_reset();
        step(1'b1, 8'h33, 1'b0, 1'b0);
        step(1'b1, 8'h33, 1'b0, 1'b0);
        rx_rs = 1'b1;
        do_reset();
        step(1'b1, 8'h66, 1'b0, 1'b0);
        check("t7_count", count, 1);
        check("t7_dout",  dout,  8'h66);
        check("t7_ack",   rx_over_read, 1);
        step(1'b0, 8'h00, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rx_fifo.md
RX_FIFO -- requirements
Module: rx_fifo

Interface
REQ-001 Parameter DEPTH, default 8, FIFO entries; SHALL be a power of two, 2..16.
REQ-002 Parameter AW, default 3, pointer width; SHALL equal log2(DEPTH).
REQ-003 clk  input  1  clock; all state SHALL update on rising edge.
REQ-004 rst  input  1  reset; SHALL be asynchronous and active-high.
REQ-005 rx_data  input  8  received byte from the receive unit, valid while rx_rs=1.
REQ-006 rx_rs  input  1  receive-unit byte-available status (level).
REQ-007 rx_over_read  output  1  single-cycle registered pulse to the receive unit's over_read input, acknowledging the byte.
REQ-008 rd  input  1  CPU pop strobe; each high cycle SHALL request one pop.
REQ-009 dout  output  8  head entry, show-ahead (valid while empty=0).
REQ-010 empty  output  1  high when count=0.
REQ-011 full  output  1  high when count=DEPTH.
REQ-012 count  output  AW+1  number of stored bytes, 0..DEPTH.
REQ-013 overrun  output  1  sticky flag: a byte was dropped.
REQ-014 clr_ovr  input  1  CPU clear of overrun.

Function
REQ-015 Capture FSM SHALL have states IDLE, ACK, WAIT_CLR.
REQ-016 IDLE: rx_rs=1 SHALL sample rx_data, attempt a push in the same edge, and go to ACK.
REQ-017 ACK: rx_over_read SHALL be 1 for exactly this one cycle; next state WAIT_CLR.
REQ-018 WAIT_CLR: SHALL stay until rx_rs=0, then go to IDLE; no push SHALL occur in ACK or WAIT_CLR.
REQ-019 Each rx_rs assertion SHALL therefore yield at most one push and exactly one rx_over_read pulse.
REQ-020 Push SHALL succeed when full=0, or when full=1 and rd=1 in the same cycle.
REQ-021 A failed push SHALL discard the byte, set overrun, and still issue rx_over_read.
REQ-022 Pop SHALL occur when rd=1 and empty=0; rd while empty SHALL be ignored with no state change.
REQ-023 Simultaneous push and pop SHALL leave count unchanged and advance both pointers.
REQ-024 Pointers SHALL be AW bits and wrap from DEPTH-1 to 0.
REQ-025 dout SHALL equal mem[rptr] combinationally; a popped byte SHALL be replaced on dout by the next entry in the cycle after the pop edge.
REQ-026 A pushed byte SHALL be visible on dout the cycle after the push edge if the FIFO was empty.
REQ-027 overrun SHALL clear on clr_ovr=1; if clr_ovr and a new drop coincide, overrun SHALL be 1.
REQ-028 Latency rx_rs rising to empty falling SHALL be 1 clock.

Reset
REQ-029 rst=1 SHALL immediately force FSM=IDLE, pointers=0, count=0, empty=1, full=0, overrun=0, rx_over_read=0, all memory entries=0 (dout=0x00).
REQ-030 Reset asserted mid-handshake (ACK or WAIT_CLR) SHALL abort it; after release, a still-high rx_rs SHALL be treated as a new byte in IDLE.

Verification
REQ-031 Reset, rx_rs pulse with rx_data=0x55 -> one rx_over_read pulse 1 cycle later, count=1, dout=0x55, empty=0.
REQ-032 Push 0x01..0x08 with no rd -> full=1, count=8; ninth byte 0x09 -> dropped, overrun=1, rx_over_read still pulsed, dout=0x01.
REQ-033 Full FIFO, byte 0x0A arrives in the same cycle as rd=1 -> count stays 8, 0x0A stored at tail, overrun unchanged, dout=0x02.
REQ-034 Push 12 bytes interleaved with 12 pops -> pointers wrap, output order matches input order, final count=0, empty=1.
REQ-035 rx_rs held high for 20 cycles -> exactly one push and one rx_over_read pulse.
REQ-036 rd on empty FIFO, then clr_ovr coinciding with a drop -> count stays 0, then overrun=1.
